dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters.
  - The pipeline memory stage: CPU port, highest priority, no handshake.
  - An external loader/debug master: EXT port, valid/ready request plus a response strobe.
- Sits between the memory stage and the dmem instance, after byte-lane encoding, so all addresses are word addresses.
- Optionally bounds EXT starvation by stalling the CPU for one cycle.

Parameters:
- ADDR_W, 11, dmem word-address width.
- MAX_WAIT, 8, consecutive blocked EXT cycles before a forced EXT grant. Range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- cpu_read  in  1  memory stage load this cycle.
- cpu_writeb  in  4  memory stage byte write enables; nonzero means store.
- cpu_addr  in  ADDR_W  memory stage word address.
- cpu_wdata  in  32  memory stage encoded write data.
- cpu_stall  out  1  memory stage must hold its request this cycle; dmem is given to EXT.
- ext_req_valid  in  1  EXT request pending.
- ext_req_ready  out  1  EXT request accepted this cycle.
- ext_req_write  in  1  1 = write, 0 = read.
- ext_req_writeb  in  4  EXT byte enables; ignored for reads.
- ext_req_addr  in  ADDR_W  EXT word address.
- ext_req_wdata  in  32  EXT write data.
- ext_rsp_valid  out  1  EXT read data valid.
- ext_rsp_rdata  out  32  EXT read data.
- dmem_read  out  1  to dmem.
- dmem_writeb  out  4  to dmem.
- dmem_addr  out  ADDR_W  to dmem.
- dmem_wdata  out  32  to dmem.
- dmem_rdata  in  32  from dmem; valid the cycle after a read.

Behaviour:
- CPU active: cpu_busy = cpu_read || (cpu_writeb != 0).
- Grant, combinational, same cycle:
  - grant_ext = ext_req_valid && (!cpu_busy || force).
  - Otherwise the CPU owns the dmem.
- dmem mux:
  - grant_ext = 1: dmem_read = !ext_req_write; dmem_writeb = ext_req_write ? ext_req_writeb : 0; addr and wdata from EXT.
  - grant_ext = 0: CPU signals pass through unchanged.
- ext_req_ready = grant_ext. A request transfers when valid && ready. EXT holds all request fields stable until ready.
- cpu_stall = grant_ext && cpu_busy. Only possible when force = 1.
- Read response:
  - Registered flag rsp_pend <= grant_ext && !ext_req_write.
  - ext_rsp_valid = rsp_pend.
  - ext_rsp_rdata = dmem_rdata when rsp_pend, else 0.
  - Latency is exactly 1 cycle after acceptance. Back-to-back EXT reads give back-to-back responses. There is no response backpressure.
- EXT write with writeb = 0: accepted, no memory effect, no response.
- The CPU reads dmem_rdata directly. The arbiter never delays CPU read data except by stall.
- Starvation FSM, two states:
  - WAIT: ext_req_valid && cpu_busy && !grant_ext increments wait_cnt (8 bit, saturating).
    - When wait_cnt == MAX_WAIT-1 and the EXT is still blocked, go to FORCE.
  - FORCE: force = 1 for exactly one cycle.
    - The EXT is granted because ext_req_valid is still held.
    - Clear wait_cnt and return to WAIT.
    - If ext_req_valid dropped, return to WAIT with no grant.
  - Any EXT transfer clears wait_cnt.
  - ext_req_valid = 0 clears wait_cnt.
- Simultaneous CPU load + EXT read when not forced: CPU wins, EXT waits.
- Reset (asynchronous, may land mid-operation):
  - State = WAIT, wait_cnt = 0, rsp_pend = 0.
  - ext_rsp_valid = 0, ext_rsp_rdata = 0, cpu_stall = 0.
  - ext_req_ready = 0 while rst is asserted.
  - A read accepted the cycle before reset produces no response.
- While rst is asserted, all dmem_* outputs = 0; no spurious writes.

Optional Feature:
- Macro DMEM_ARB_STARVE_EN.
  - Defined: starvation FSM and wait_cnt present as above.
  - Undefined: strict CPU priority.
    - force = 0, so cpu_stall is constant 0.
    - No counter logic; MAX_WAIT is unused.
    - The EXT may starve indefinitely.

Decomposition:
- Shared package/header holds:
  - arbiter state encodings: ARB_WAIT, ARB_FORCE.
  - DMEM_ADDR_W default.
  - The existing dmem width encodings (byte/half/word) are reused unchanged.
- One natural sub-module: dmem_arb_starve.
  - Contains the wait counter and FSM.
  - Inputs: ext_req_valid, cpu_busy, grant_ext.
  - Output: force.
  - Instantiated only under DMEM_ARB_STARVE_EN.

Test Plan:
- CPU idle; EXT read addr 0x010 holding 0xDEADBEEF → ready same cycle; ext_rsp_valid 1 cycle later with rdata 0xDEADBEEF.
- CPU store writeb=4'b1111 to 0x020 and EXT write to 0x020 in the same cycle → CPU data lands in memory; EXT ready=0; EXT write completes the next idle cycle.
- STARVE_EN, MAX_WAIT=8; CPU busy every cycle with EXT valid → ready=0 for 8 cycles; on the 9th cycle ready=1 and cpu_stall=1 for exactly 1 cycle; counter restarts.
- STARVE_EN undefined, same stimulus for 100 cycles → ready never asserts; cpu_stall stays 0.
- Four back-to-back EXT reads at 0x000..0x003 with CPU idle → four consecutive ext_rsp_valid cycles with data in address order.
- rst asserted in the cycle after an accepted EXT read → ext_rsp_valid stays 0; dmem_writeb=0 during reset; wait_cnt=0 after release.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Width encodings are those already used by the memory stage.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W = 11;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_width_e;

    typedef enum logic {
        ARB_WAIT  = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_arb_starve.sv
// EXT starvation guard: counts consecutive blocked EXT cycles and
// raises force_ext for one cycle once MAX_WAIT have gone by.
module dmem_arb_starve
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ext_req_valid,
    input  logic cpu_busy,
    input  logic grant_ext,
    output logic force_ext
);

    localparam logic [7:0] LastWait = 8'(MAX_WAIT - 1);

    arb_state_e state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       blocked;

    assign blocked = ext_req_valid && cpu_busy && !grant_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_WAIT;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        force_ext  = 1'b0;
        unique case (state_q)
            ARB_WAIT: begin
                if (!ext_req_valid || grant_ext) begin
                    wait_cnt_d = '0;
                end else if (blocked) begin
                    if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                    if (wait_cnt_q >= LastWait) begin
                        state_d = ARB_FORCE;
                    end
                end
            end
            ARB_FORCE: begin
                // one-shot: grant happens only if EXT still holds valid
                force_ext  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ARB_WAIT;
            end
            default: begin
                state_d    = ARB_WAIT;
                wait_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: CPU has priority, EXT gets idle cycles.
// DMEM_ARB_STARVE_EN adds a bounded-wait forced EXT grant.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int          ADDR_W   = DMEM_ADDR_W,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic [3:0]        cpu_writeb,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    input  logic              ext_req_valid,
    output logic              ext_req_ready,
    input  logic              ext_req_write,
    input  logic [3:0]        ext_req_writeb,
    input  logic [ADDR_W-1:0] ext_req_addr,
    input  logic [31:0]       ext_req_wdata,
    output logic              ext_rsp_valid,
    output logic [31:0]       ext_rsp_rdata,
    output logic              dmem_read,
    output logic [3:0]        dmem_writeb,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata
);

    logic cpu_busy;
    logic grant_ext;
    logic force_ext;
    logic rsp_pend_q, rsp_pend_d;

    assign cpu_busy = cpu_read || (cpu_writeb != 4'b0);

`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_starve #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk          (clk),
        .rst          (rst),
        .ext_req_valid(ext_req_valid),
        .cpu_busy     (cpu_busy),
        .grant_ext    (grant_ext),
        .force_ext    (force_ext)
    );
`else
    logic [7:0] unused_max_wait;
    assign unused_max_wait = 8'(MAX_WAIT);
    assign force_ext       = 1'b0;
`endif

    // reset blanks every grant so nothing reaches dmem mid-reset
    assign grant_ext     = !rst && ext_req_valid && (!cpu_busy || force_ext);
    assign ext_req_ready = grant_ext;
    assign cpu_stall     = grant_ext && cpu_busy;

    always_comb begin
        dmem_read   = 1'b0;
        dmem_writeb = 4'b0;
        dmem_addr   = '0;
        dmem_wdata  = '0;
        if (rst) begin
            dmem_read = 1'b0;
        end else if (grant_ext) begin
            dmem_read   = !ext_req_write;
            dmem_writeb = ext_req_write ? ext_req_writeb : 4'b0;
            dmem_addr   = ext_req_addr;
            dmem_wdata  = ext_req_wdata;
        end else begin
            dmem_read   = cpu_read;
            dmem_writeb = cpu_writeb;
            dmem_addr   = cpu_addr;
            dmem_wdata  = cpu_wdata;
        end
    end

    assign rsp_pend_d = grant_ext && !ext_req_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_pend_q <= 1'b0;
        end else begin
            rsp_pend_q <= rsp_pend_d;
        end
    end

    assign ext_rsp_valid = rsp_pend_q;
    assign ext_rsp_rdata = rsp_pend_q ? dmem_rdata : 32'b0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised + directed bench for dmem_arbiter with a cycle-level
// reference model and a behavioural single-port dmem.
module tb_dmem_arbiter;

    localparam int AW   = 11;
    localparam int MAXW = 8;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_read;
    logic [3:0]    cpu_writeb;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_stall;
    logic          ext_req_valid;
    logic          ext_req_ready;
    logic          ext_req_write;
    logic [3:0]    ext_req_writeb;
    logic [AW-1:0] ext_req_addr;
    logic [31:0]   ext_req_wdata;
    logic          ext_rsp_valid;
    logic [31:0]   ext_rsp_rdata;
    logic          dmem_read;
    logic [3:0]    dmem_writeb;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_rdata;

    dmem_arbiter #(
        .ADDR_W  (AW),
        .MAX_WAIT(MAXW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_read      (cpu_read),
        .cpu_writeb    (cpu_writeb),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_stall     (cpu_stall),
        .ext_req_valid (ext_req_valid),
        .ext_req_ready (ext_req_ready),
        .ext_req_write (ext_req_write),
        .ext_req_writeb(ext_req_writeb),
        .ext_req_addr  (ext_req_addr),
        .ext_req_wdata (ext_req_wdata),
        .ext_rsp_valid (ext_rsp_valid),
        .ext_rsp_rdata (ext_rsp_rdata),
        .dmem_read     (dmem_read),
        .dmem_writeb   (dmem_writeb),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0]  be);
        merge = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merge[8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    bit [31:0] mem [2048];
    bit [31:0] ref_mem [2048];

    always @(posedge clk) begin
        if (dmem_writeb != 4'b0)
            mem[dmem_addr] <= merge(mem[dmem_addr], dmem_wdata, dmem_writeb);
        if (dmem_read)
            dmem_rdata <= mem[dmem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    int          blk = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_data = '0;
    bit          last_g = 1'b0;
    bit          last_stall = 1'b0;
    logic        s_ready, s_stall, s_rvalid;
    logic [3:0]  s_wb;
    logic [31:0] s_rdata;

    task automatic cycle();
        logic          busy, frc, g, e_rd, e_pend;
        logic [3:0]    e_wb;
        logic [AW-1:0] e_a;
        logic [31:0]   e_wd;
        @(negedge clk);
        busy = cpu_read || (cpu_writeb != 4'b0);
        frc  = STARVE && (blk >= MAXW);
        g    = !rst && ext_req_valid && (!busy || frc);
        e_rd = 1'b0; e_wb = '0; e_a = '0; e_wd = '0;
        if (!rst && g) begin
            e_rd = !ext_req_write;
            e_wb = ext_req_write ? ext_req_writeb : 4'b0;
            e_a  = ext_req_addr;
            e_wd = ext_req_wdata;
        end else if (!rst) begin
            e_rd = cpu_read;
            e_wb = cpu_writeb;
            e_a  = cpu_addr;
            e_wd = cpu_wdata;
        end
        e_pend = pend && !rst;
        chk("ready", 32'(ext_req_ready), 32'(g));
        chk("stall", 32'(cpu_stall), 32'(g && busy));
        chk("dmem_read", 32'(dmem_read), 32'(e_rd));
        chk("dmem_writeb", 32'(dmem_writeb), 32'(e_wb));
        chk("dmem_addr", 32'(dmem_addr), 32'(e_a));
        chk("dmem_wdata", dmem_wdata, e_wd);
        chk("rsp_valid", 32'(ext_rsp_valid), 32'(e_pend));
        chk("rsp_rdata", ext_rsp_rdata, e_pend ? pend_data : 32'h0);
        s_ready  = ext_req_ready;
        s_stall  = cpu_stall;
        s_rvalid = ext_rsp_valid;
        s_rdata  = ext_rsp_rdata;
        s_wb     = dmem_writeb;
        last_g     = g;
        last_stall = g && busy;
        @(posedge clk);
        if (rst) begin
            blk  = 0;
            pend = 1'b0;
        end else begin
            pend = g && !ext_req_write;
            if (pend) pend_data = ref_mem[ext_req_addr];
            if (e_wb != 4'b0) ref_mem[e_a] = merge(ref_mem[e_a], e_wd, e_wb);
            if (frc || !ext_req_valid || g) blk = 0;
            else if (blk < 255) blk = blk + 1;
        end
        #1;
    endtask

    task automatic cpu_idle();
        cpu_read = 1'b0; cpu_writeb = '0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic ext_idle();
        ext_req_valid = 1'b0; ext_req_write = 1'b0; ext_req_writeb = '0;
        ext_req_addr = '0; ext_req_wdata = '0;
    endtask

    task automatic cpu_wr(input int a, input logic [31:0] d);
        cpu_read = 1'b0; cpu_writeb = 4'hF; cpu_addr = AW'(a); cpu_wdata = d;
    endtask

    task automatic cpu_rd(input int a);
        cpu_read = 1'b1; cpu_writeb = '0; cpu_addr = AW'(a); cpu_wdata = '0;
    endtask

    task automatic ext_rd(input int a);
        ext_req_valid = 1'b1; ext_req_write = 1'b0; ext_req_writeb = '0;
        ext_req_addr = AW'(a); ext_req_wdata = '0;
    endtask

    task automatic ext_wr(input int a, input logic [31:0] d, input logic [3:0] be);
        ext_req_valid = 1'b1; ext_req_write = 1'b1; ext_req_writeb = be;
        ext_req_addr = AW'(a); ext_req_wdata = d;
    endtask

    initial begin
        int first, grants, stalls, n;
        rst = 1'b1;
        cpu_idle();
        ext_idle();
        // reset with traffic present: nothing may reach dmem
        cpu_wr(3, 32'h55AA55AA);
        ext_rd(4);
        cycle();
        chk("reset_writeb", 32'(s_wb), 32'h0);
        chk("reset_ready", 32'(s_ready), 32'h0);
        rst = 1'b0;
        cpu_idle(); ext_idle();
        cycle();

        // simple EXT read with CPU idle
        cpu_wr(16, 32'hDEADBEEF);
        cycle();
        cpu_idle(); ext_rd(16);
        cycle();
        chk("ext_rd_ready", 32'(s_ready), 32'h1);
        ext_idle();
        cycle();
        chk("ext_rd_valid", 32'(s_rvalid), 32'h1);
        chk("ext_rd_data", s_rdata, 32'hDEADBEEF);

        // same-cycle CPU store and EXT write to one word
        cpu_wr(32, 32'h11111111);
        ext_wr(32, 32'h22222222, 4'hF);
        cycle();
        chk("collide_ready", 32'(s_ready), 32'h0);
        chk("collide_cpu_mem", mem[32], 32'h11111111);
        cpu_idle();
        cycle();
        chk("collide_ext_ready", 32'(s_ready), 32'h1);
        ext_idle();
        cycle();
        chk("collide_ext_mem", mem[32], 32'h22222222);

        // CPU busy every cycle, EXT read held
        n = STARVE ? 27 : 100;
        first = 0; grants = 0; stalls = 0;
        cpu_rd(5); ext_rd(7);
        for (int i = 1; i <= n; i++) begin
            cycle();
            if (s_ready) begin
                grants++;
                if (first == 0) first = i;
            end
            if (s_stall) stalls++;
        end
        chk("starve_first", 32'(first), STARVE ? 32'd9 : 32'd0);
        chk("starve_grants", 32'(grants), STARVE ? 32'd3 : 32'd0);
        chk("starve_stalls", 32'(stalls), STARVE ? 32'd3 : 32'd0);
        cpu_idle(); ext_idle();
        cycle();

        // four back-to-back EXT reads
        for (int i = 0; i < 4; i++) begin
            cpu_wr(i, 32'hA0000000 + 32'(i));
            cycle();
        end
        cpu_idle();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) ext_rd(k);
            else ext_idle();
            cycle();
            if (k >= 1) begin
                chk("b2b_valid", 32'(s_rvalid), 32'h1);
                chk("b2b_data", s_rdata, 32'hA0000000 + 32'(k - 1));
            end
        end

        // reset right after an accepted read
        cpu_rd(1); ext_rd(2);
        repeat (5) cycle();
        cpu_idle();
        cycle();
        chk("pre_rst_ready", 32'(s_ready), 32'h1);
        rst = 1'b1;
        cpu_wr(48, 32'hCAFEF00D);
        ext_wr(48, 32'h0BADF00D, 4'hF);
        cycle();
        chk("rst_rsp_valid", 32'(s_rvalid), 32'h0);
        chk("rst_writeb", 32'(s_wb), 32'h0);
        chk("rst_no_write", mem[48], 32'h0);
        rst = 1'b0;
        cpu_idle(); ext_idle();
        cycle();

        // partial wait count must not survive reset
        cpu_rd(1); ext_rd(2);
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        first = 0;
        for (int i = 1; i <= 9; i++) begin
            cycle();
            if (s_ready && first == 0) first = i;
        end
        chk("rst_cnt_clear", 32'(first), STARVE ? 32'd9 : 32'd0);
        cpu_idle(); ext_idle();
        cycle();

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            if (!last_stall) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 3) cpu_idle();
                else if (r < 6) cpu_rd(int'($urandom_range(0, 15)));
                else begin
                    cpu_read   = 1'b0;
                    cpu_writeb = 4'($urandom_range(0, 15));
                    cpu_addr   = AW'($urandom_range(0, 15));
                    cpu_wdata  = $urandom;
                end
            end
            if (!ext_req_valid || last_g) begin
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 1) == 1)
                        ext_wr(int'($urandom_range(0, 15)), $urandom,
                               4'($urandom_range(0, 15)));
                    else
                        ext_rd(int'($urandom_range(0, 15)));
                end else begin
                    ext_idle();
                end
            end
            cycle();
        end
        cpu_idle(); ext_idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
